w_grf_writer: RTL
=================

// Module: w_grf_writer
// PURPOSE
//  Write-side driver for the general register file (GRF) write port. Each cycle it selects one write
//  from two producers: the W-stage pipeline write, which has priority, and an auxiliary multi-cycle
//  producer (MDU / late-load unit), which is buffered in a FIFO.
//  Drives the GRF A3/WD/RFWr/pc inputs from registers, tracks buffered destinations for the hazard
//  unit, and raises a stall request so the aux producer cannot starve.
// PARAMETERS
//  DEPTH       4   aux FIFO entries; power of two, >=2
//  STARVE_MAX  8   cycles a non-empty FIFO head may wait before stall_req asserts; >=1
// PORTS
//  clk        in   1   single clock, rising edge
//  reset      in   1   asynchronous, active-high; clears all state immediately
//  w_we       in   1   W-stage write request
//  w_a3       in   5   W-stage destination register
//  w_wd       in   32  W-stage write data
//  w_pc       in   32  W-stage instruction PC
//  aux_valid  in   1   aux write request valid
//  aux_ready  out  1   FIFO can accept (= !full)
//  aux_a3     in   5   aux destination register
//  aux_wd     in   32  aux write data
//  aux_pc     in   32  aux instruction PC
//  grf_we     out  1   to GRF RFWr
//  grf_a3     out  5   to GRF A3
//  grf_wd     out  32  to GRF WD
//  grf_pc     out  32  to GRF pc (trace)
//  stall_req  out  1   to hazard unit: freeze the W stage
//  pend_mask  out  32  bit r = 1 while a write to $r sits in the FIFO
// BEHAVIOUR
//  - Reset: grf_we/grf_a3/grf_wd/grf_pc/stall_req/pend_mask = 0; FIFO empty; starve counter 0;
//    aux_ready = 1.
//  - Handshake: an aux write is accepted on a clk edge with aux_valid && aux_ready.
//    aux_ready depends only on full; there is no same-cycle pass-through.
//    An accepted aux write with aux_a3==0 is discarded and not enqueued.
//  - Arbitration, one winner per cycle, registered into grf_* (1-cycle latency):
//    1) stall_req==0 && w_we && w_a3!=0 -> pipeline write.
//    2) else FIFO non-empty -> pop the head.
//    3) else grf_we=0. grf_a3/grf_wd/grf_pc keep their last values.
//  - w_we with w_a3==0 is not a write. It never blocks the FIFO.
//  - Starvation counter:
//    increments each cycle the FIFO is non-empty and not popped;
//    clears on a pop or when the FIFO is empty.
//    When it reaches STARVE_MAX, stall_req is registered high the next cycle.
//  - While stall_req==1: w_* are ignored (the W stage is frozen and re-presents the same write),
//    and the FIFO is popped every cycle. stall_req drops on the edge where the FIFO becomes empty.
//  - Full + push + pop in one cycle: legal. aux_ready was already 0, so no push happens; only the pop.
//  - Ordering: a pipeline write and a queued aux write to the same register complete in arbitration
//    order. The hazard unit uses pend_mask to avoid conflicts; this block does not reorder.
//  - Reset mid-operation: FIFO contents are lost, and any in-flight grf_we drops immediately.
// CONFIGURATION
//  WB_PEND_MASK_EN defined:
//    pend_mask = OR over valid FIFO entries of one-hot(a3).
//    Registered; updates on the same edge as the push/pop.
//  WB_PEND_MASK_EN undefined:
//    pend_mask tied to 32'b0, and no tracking logic is built.
//    The hazard unit must then stall on aux_valid||!empty conservatively.
// STRUCTURE
//  - Shared header macro.v:
//    `REG_ZERO (5'd0);
//    `WB_ENTRY_W (69 = 5+32+32);
//    field offsets of the {a3,wd,pc} FIFO entry.
//  - Sub-module wb_fifo:
//    DEPTH x `WB_ENTRY_W;
//    push/pop/full/empty outputs;
//    wrap-around read/write pointers plus a count;
//    asynchronous reset.
//  - Top level: arbiter, starvation counter, output registers, pend_mask logic.
// TESTING
//  1. Pipeline only: w_we=1, a3=5, wd=32'h1234 -> next cycle grf_we=1, a3=5, wd=32'h1234.
//     w_a3=0 -> grf_we=0.
//  2. Aux only: push a3=7, wd=32'hBEEF -> written one cycle after the push.
//     Four pushes with no pipeline traffic -> four consecutive writes, in order.
//  3. Full: push DEPTH entries while w_we=1 every cycle -> aux_ready=0 after 4 pushes.
//     Further aux_valid is not accepted. No entry is lost.
//  4. Starvation: FIFO holds 2 entries, w_we=1 continuously -> stall_req=1 after STARVE_MAX+1 cycles.
//     Both entries are then written on back-to-back cycles, and stall_req=0 after the last pop.
//  5. Pending mask (WB_PEND_MASK_EN): push a3=3 and a3=9 -> pend_mask=32'h208.
//     After both pops -> 0. With the macro undefined, pend_mask stays 0.
//  6. Async reset asserted mid-drain with 3 entries queued -> grf_we=0 and aux_ready=1 without a
//     clock edge. After reset releases there are no writes.

Source files
------------

// File: rtl/w_grf_writer_pkg.sv
// Shared types and constants for the GRF write-port driver: register-zero index,
// aux FIFO entry layout {a3, wd, pc} and the arbitration source encoding.
package w_grf_writer_pkg;

   localparam int A3_W   = 5;
   localparam int DATA_W = 32;

   localparam logic [A3_W-1:0] REG_ZERO = 5'd0;

   localparam int WB_ENTRY_W = A3_W + DATA_W + DATA_W;
   localparam int ENT_PC_LSB = 0;
   localparam int ENT_WD_LSB = DATA_W;
   localparam int ENT_A3_LSB = DATA_W + DATA_W;

   typedef enum logic [1:0] {
      SRC_NONE = 2'd0,
      SRC_PIPE = 2'd1,
      SRC_AUX  = 2'd2
   } wb_src_e;

   function automatic logic [31:0] reg_onehot(input logic [A3_W-1:0] a3);
      reg_onehot = 32'd1 << a3;
   endfunction

endpackage

// File: rtl/w_grf_writer_if.sv
// Bus bundle between the W stage / aux producer / GRF / hazard unit and w_grf_writer.
// The slave modport is the writer's view; master is the environment's view.
interface w_grf_writer_if;

   logic        w_we;
   logic [4:0]  w_a3;
   logic [31:0] w_wd;
   logic [31:0] w_pc;
   logic        aux_valid;
   logic        aux_ready;
   logic [4:0]  aux_a3;
   logic [31:0] aux_wd;
   logic [31:0] aux_pc;
   logic        grf_we;
   logic [4:0]  grf_a3;
   logic [31:0] grf_wd;
   logic [31:0] grf_pc;
   logic        stall_req;
   logic [31:0] pend_mask;

   modport slave (
      input  w_we, w_a3, w_wd, w_pc,
      input  aux_valid, aux_a3, aux_wd, aux_pc,
      output aux_ready,
      output grf_we, grf_a3, grf_wd, grf_pc,
      output stall_req, pend_mask
   );

   modport master (
      output w_we, w_a3, w_wd, w_pc,
      output aux_valid, aux_a3, aux_wd, aux_pc,
      input  aux_ready,
      input  grf_we, grf_a3, grf_wd, grf_pc,
      input  stall_req, pend_mask
   );

endinterface

// File: rtl/w_grf_writer_wb_fifo.sv
// Aux write FIFO: wrap-around pointers plus occupancy count, asynchronous reset.
// With WB_PEND_MASK_EN defined it also exports its slots and which survive this edge.
module wb_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 69
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      push,
   input  logic                      pop,
   input  logic [W-1:0]              wdata,
   output logic [W-1:0]              rdata,
   output logic                      full,
   output logic                      empty,
`ifdef WB_PEND_MASK_EN
   output logic [DEPTH-1:0]          slot_live,
   output logic [DEPTH-1:0][W-1:0]   slots,
`endif
   output logic                      one_left
);

   localparam int PW = $clog2(DEPTH);

   logic [DEPTH-1:0][W-1:0] mem_r;
   logic [PW-1:0]           wr_ptr_r;
   logic [PW-1:0]           rd_ptr_r;
   logic [PW:0]             count_r;
   logic                    do_push_s;
   logic                    do_pop_s;

   assign do_push_s = push && !full;
   assign do_pop_s  = pop && !empty;
   assign full      = (count_r == (PW+1)'(DEPTH));
   assign empty     = (count_r == {(PW+1){1'b0}});
   assign one_left  = (count_r == {{PW{1'b0}}, 1'b1});
   assign rdata     = mem_r[rd_ptr_r];

   // Entry storage; contents are don't-care until counted valid.
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_r[wr_ptr_r] <= wdata;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         count_r  <= {(PW+1){1'b0}};
      end else begin
         if (do_push_s) begin
            wr_ptr_r <= wr_ptr_r + {{(PW-1){1'b0}}, 1'b1};
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + {{(PW-1){1'b0}}, 1'b1};
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + {{PW{1'b0}}, 1'b1};
            2'b01:   count_r <= count_r - {{PW{1'b0}}, 1'b1};
            default: count_r <= count_r;
         endcase
      end
   end

`ifdef WB_PEND_MASK_EN
   logic [PW-1:0] off_s;

   assign slots = mem_r;

   // A slot is live after this edge if it is occupied and not the head being popped.
   always_comb begin
      slot_live = {DEPTH{1'b0}};
      off_s     = {PW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
         off_s        = PW'(i) - rd_ptr_r;
         slot_live[i] = ({1'b0, off_s} < count_r) && !(do_pop_s && (off_s == {PW{1'b0}}));
      end
   end
`endif

endmodule

// File: rtl/w_grf_writer.sv
// GRF write-port driver: W-stage writes win, aux writes queue in wb_fifo, a starvation
// counter forces a drain via stall_req. Optional pend_mask tracking under WB_PEND_MASK_EN.
module w_grf_writer
   import w_grf_writer_pkg::*;
#(
   parameter int DEPTH      = 4,
   parameter int STARVE_MAX = 8
) (
   input logic             clk,
   input logic             reset,
   w_grf_writer_if.slave   bus
);

   localparam int CW = $clog2(STARVE_MAX + 1);

   logic [WB_ENTRY_W-1:0] head_s;
   logic                  full_s;
   logic                  empty_s;
   logic                  one_left_s;
   logic                  push_s;
   logic                  pop_s;
   wb_src_e               src_s;
   logic [CW-1:0]         starve_r;
   logic                  stall_r;
   logic                  stall_next_s;
   logic                  grf_we_r;
   logic [A3_W-1:0]       grf_a3_r;
   logic [DATA_W-1:0]     grf_wd_r;
   logic [DATA_W-1:0]     grf_pc_r;

`ifdef WB_PEND_MASK_EN
   logic [DEPTH-1:0]                 slot_live_s;
   logic [DEPTH-1:0][WB_ENTRY_W-1:0] slots_s;
`endif

   // Writes to $0 are dropped at the door so they never occupy a slot.
   assign push_s = bus.aux_valid && !full_s && (bus.aux_a3 != REG_ZERO);
   assign pop_s  = (src_s == SRC_AUX);

   wb_fifo #(.DEPTH(DEPTH), .W(WB_ENTRY_W)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push_s),
      .pop       (pop_s),
      .wdata     ({bus.aux_a3, bus.aux_wd, bus.aux_pc}),
      .rdata     (head_s),
      .full      (full_s),
      .empty     (empty_s),
`ifdef WB_PEND_MASK_EN
      .slot_live (slot_live_s),
      .slots     (slots_s),
`endif
      .one_left  (one_left_s)
   );

   // Arbitration: a live pipeline write wins unless the W stage is frozen.
   always_comb begin
      src_s = SRC_NONE;
      if (!stall_r && bus.w_we && (bus.w_a3 != REG_ZERO)) begin
         src_s = SRC_PIPE;
      end else if (!empty_s) begin
         src_s = SRC_AUX;
      end else begin
         src_s = SRC_NONE;
      end
   end

   // GRF port registers; address/data hold their last value on idle cycles.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         grf_we_r <= 1'b0;
         grf_a3_r <= 5'd0;
         grf_wd_r <= 32'd0;
         grf_pc_r <= 32'd0;
      end else begin
         case (src_s)
            SRC_PIPE: begin
               grf_we_r <= 1'b1;
               grf_a3_r <= bus.w_a3;
               grf_wd_r <= bus.w_wd;
               grf_pc_r <= bus.w_pc;
            end
            SRC_AUX: begin
               grf_we_r <= 1'b1;
               grf_a3_r <= head_s[ENT_A3_LSB +: A3_W];
               grf_wd_r <= head_s[ENT_WD_LSB +: DATA_W];
               grf_pc_r <= head_s[ENT_PC_LSB +: DATA_W];
            end
            default: grf_we_r <= 1'b0;
         endcase
      end
   end

   // Stall holds until the edge on which the last queued entry leaves.
   always_comb begin
      stall_next_s = stall_r;
      if (stall_r) begin
         stall_next_s = !empty_s && !(one_left_s && pop_s && !push_s);
      end else begin
         stall_next_s = (starve_r == CW'(STARVE_MAX)) && !pop_s;
      end
   end

   // Starvation counter and stall register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         starve_r <= {CW{1'b0}};
         stall_r  <= 1'b0;
      end else begin
         stall_r <= stall_next_s;
         if (empty_s || pop_s) begin
            starve_r <= {CW{1'b0}};
         end else if (starve_r != CW'(STARVE_MAX)) begin
            starve_r <= starve_r + {{(CW-1){1'b0}}, 1'b1};
         end else begin
            starve_r <= starve_r;
         end
      end
   end

`ifdef WB_PEND_MASK_EN
   logic [31:0] pend_next_s;
   logic [31:0] pend_r;

   // Rebuild the mask from the FIFO's post-edge contents so duplicates stay correct.
   always_comb begin
      pend_next_s = push_s ? reg_onehot(bus.aux_a3) : 32'd0;
      for (int i = 0; i < DEPTH; i++) begin
         if (slot_live_s[i]) begin
            pend_next_s = pend_next_s | reg_onehot(slots_s[i][ENT_A3_LSB +: A3_W]);
         end else begin
            pend_next_s = pend_next_s;
         end
      end
   end

   // Pending-destination mask register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_r <= 32'd0;
      end else begin
         pend_r <= pend_next_s;
      end
   end

   assign bus.pend_mask = pend_r;
`else
   assign bus.pend_mask = 32'd0;
`endif

   assign bus.aux_ready = !full_s;
   assign bus.grf_we    = grf_we_r;
   assign bus.grf_a3    = grf_a3_r;
   assign bus.grf_wd    = grf_wd_r;
   assign bus.grf_pc    = grf_pc_r;
   assign bus.stall_req = stall_r;

endmodule
